sw_debounce: RTL and testbench
==============================

SW_DEBOUNCE -- requirements
Module: sw_debounce

Interface
- REQ-001: Parameter DEB_CNT, default 100000, number of extra consecutive stable samples required before the output changes (1 ms at 100 MHz); legal range 2..2^24.
- REQ-002: clk  input  1  single system clock; all state updates on its rising edge.
- REQ-003: reset  input  1  synchronous, active-high reset, sampled on rising clk.
- REQ-004: sw_in  input  1  raw, bouncing, asynchronous mechanical switch level.
- REQ-005: sw_out  output  1  debounced switch level, registered; drives the sw input of the downstream Moore FSM.
- REQ-006: sw_rise  output  1  registered one-cycle pulse on each debounced 0->1 transition.

Function
- REQ-007: The internal sample s SHALL be sw_in after the optional synchronizer (REQ-019/020).
- REQ-008: The Moore FSM SHALL have 4 states: LOW_STABLE, WAIT_HIGH, HIGH_STABLE, WAIT_LOW.
- REQ-009: LOW_STABLE: s=1 -> WAIT_HIGH with cnt=0; s=0 -> stay.
- REQ-010: WAIT_HIGH: s=0 -> LOW_STABLE with cnt=0; s=1 and cnt<DEB_CNT-1 -> cnt+1; s=1 and cnt==DEB_CNT-1 -> HIGH_STABLE with cnt=0.
- REQ-011: HIGH_STABLE and WAIT_LOW SHALL mirror REQ-009/010 with s inverted.
- REQ-012: sw_out SHALL be 1 in HIGH_STABLE and WAIT_LOW, and 0 in LOW_STABLE and WAIT_HIGH; it is decoded from the state register only.
- REQ-013: Latency: s high on DEB_CNT+1 consecutive rising edges SHALL make sw_out rise after the last of those edges; falling is symmetric.
- REQ-014: Any opposite sample during a WAIT state SHALL abort to the prior stable state with cnt=0. Glitches of DEB_CNT or fewer edges SHALL never change sw_out.
- REQ-015: sw_rise SHALL be 1 for exactly the first cycle in which sw_out=1 after a LOW->HIGH transition, and 0 otherwise. A falling transition SHALL produce no pulse.
- REQ-016: The counter width SHALL be $clog2(DEB_CNT). The counter SHALL never wrap; it saturates at DEB_CNT-1 only transiently, because the state changes on that edge.

Reset
- REQ-017: While reset=1 at a rising edge: state=LOW_STABLE, cnt=0, sw_out=0, sw_rise=0, synchronizer flops=0.
- REQ-018: Reset SHALL take priority over every transition, including mid-WAIT. A switch held high through reset SHALL be re-qualified from zero (DEB_CNT+1 edges after release).

Configuration
- REQ-019: Macro SW_DEBOUNCE_SYNC_EN defined: sw_in SHALL pass through a 2-flop synchronizer before the FSM, adding exactly 2 cycles to every latency in REQ-013.
- REQ-020: Macro SW_DEBOUNCE_SYNC_EN undefined: s=sw_in directly; the input is then required to be synchronous to clk (testbench use).

Structure
- REQ-021: Package sw_debounce_pkg SHALL hold the 2-bit state typedef (LOW_STABLE=0, WAIT_HIGH=1, HIGH_STABLE=2, WAIT_LOW=3) and the constant DEB_CNT_DEFAULT=100000.
- REQ-022: The synchronizer SHALL be a separate sub-module, sync_2ff (ports clk, reset, d, q), instantiated only under SW_DEBOUNCE_SYNC_EN.
- REQ-023: The FSM, counter and pulse register SHALL live in sw_debounce, with no further hierarchy.

Verification (DEB_CNT=4, SW_DEBOUNCE_SYNC_EN undefined unless stated, 10 ns clock)
- REQ-024: reset=1 for 2 edges, sw_in=0 -> sw_out=0, sw_rise=0 throughout and after release.
- REQ-025: sw_in=1 held from edge e0 -> sw_out=1 after e4, sw_rise=1 only in the cycle after e4, sw_out stays 1.
- REQ-026: Glitch: sw_in=1 for edges e0..e3, then 0 -> sw_out stays 0, sw_rise never asserts, FSM back in LOW_STABLE after e4.
- REQ-027: Falling: from HIGH_STABLE, sw_in=0 held from e0 -> sw_out=0 after e4, no sw_rise pulse.
- REQ-028: reset=1 at e2 of a stable high press, released at e3 with sw_in still 1 -> sw_out=0, then sw_out=1 after e8.
- REQ-029: With SW_DEBOUNCE_SYNC_EN defined, repeat REQ-025 -> sw_out=1 after e6.

Source files
------------

// File: rtl/sw_debounce_pkg.sv
// Shared types and constants for the switch debouncer.
// Optional build macro (used in sw_debounce): SW_DEBOUNCE_SYNC_EN.
package sw_debounce_pkg;

  localparam int DEB_CNT_DEFAULT = 100000;

  typedef enum logic [1:0] {
    LOW_STABLE  = 2'd0,
    WAIT_HIGH   = 2'd1,
    HIGH_STABLE = 2'd2,
    WAIT_LOW    = 2'd3
  } deb_state_t;

  // Counter width for DEB_CNT; never below one bit.
  function automatic int cnt_width(input int deb_cnt);
    return (deb_cnt > 2) ? $clog2(deb_cnt) : 1;
  endfunction

  // Debounced level implied by a state.
  function automatic logic level_of(input deb_state_t st);
    return (st == HIGH_STABLE) || (st == WAIT_LOW);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for the raw switch level; both flops clear on reset.
// Instantiated by sw_debounce only when SW_DEBOUNCE_SYNC_EN is defined.
module sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/sw_debounce.sv
// Switch debouncer: Moore FSM qualifies DEB_CNT+1 consecutive equal samples.
// Build macro SW_DEBOUNCE_SYNC_EN inserts a 2-flop synchronizer on sw_in.
//
// state       | meaning
// LOW_STABLE  | debounced level 0, input agrees
// WAIT_HIGH   | level 0, counting consecutive high samples
// HIGH_STABLE | debounced level 1, input agrees
// WAIT_LOW    | level 1, counting consecutive low samples
module sw_debounce
  import sw_debounce_pkg::*;
#(
  parameter int DEB_CNT = DEB_CNT_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic sw_in,
  output logic sw_out,
  output logic sw_rise
);

  localparam int             CW       = cnt_width(DEB_CNT);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DEB_CNT - 1);

  logic          s;
  deb_state_t    state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          rise_nxt;

`ifdef SW_DEBOUNCE_SYNC_EN
  sync_2ff u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (sw_in),
    .q     (s)
  );
`else
  assign s = sw_in;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= LOW_STABLE;
      cnt     <= '0;
      sw_rise <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      sw_rise <= rise_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      LOW_STABLE: begin
        if (s) begin
          state_nxt = WAIT_HIGH;
          cnt_nxt   = '0;
        end
      end
      WAIT_HIGH: begin
        if (!s) begin
          state_nxt = LOW_STABLE;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = HIGH_STABLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      HIGH_STABLE: begin
        if (!s) begin
          state_nxt = WAIT_LOW;
          cnt_nxt   = '0;
        end
      end
      WAIT_LOW: begin
        if (s) begin
          state_nxt = HIGH_STABLE;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = LOW_STABLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      default: begin
        state_nxt = LOW_STABLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // The pulse register loads on the same edge that enters HIGH_STABLE, so it
  // lines up with the first cycle of sw_out=1.
  assign rise_nxt = (state == WAIT_HIGH) && (state_nxt == HIGH_STABLE);
  assign sw_out   = level_of(state);

endmodule

// File: tb/tb_sw_debounce.sv
// Self-checking bench for sw_debounce (DEB_CNT=4): vector table, corner
// sequences, and random bursty input against a run-length reference model.
module tb_sw_debounce;

  localparam int DEB = 4;
`ifdef SW_DEBOUNCE_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic sw_in = 1'b0;
  logic sw_out, sw_rise;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  sw_debounce #(.DEB_CNT(DEB)) dut (
    .clk     (clk),
    .reset   (reset),
    .sw_in   (sw_in),
    .sw_out  (sw_out),
    .sw_rise (sw_rise)
  );

  // Reference model: output flips once DEB+1 consecutive samples disagree
  // with it; any agreeing sample clears the run. Input delayed by LAT edges.
  logic m_out  = 1'b0;
  logic m_rise = 1'b0;
  int   m_run  = 0;
  logic dq[$];

  task automatic model_edge(input logic r, input logic s);
    logic sv;
    if (r) begin
      m_out  = 1'b0;
      m_rise = 1'b0;
      m_run  = 0;
      dq.delete();
      for (int i = 0; i < LAT; i++) dq.push_back(1'b0);
    end else begin
      dq.push_back(s);
      sv     = dq.pop_front();
      m_rise = 1'b0;
      if (sv != m_out) begin
        m_run++;
        if (m_run == DEB + 1) begin
          m_out  = sv;
          m_rise = sv;
          m_run  = 0;
        end
      end else begin
        m_run = 0;
      end
    end
  endtask

  task automatic drive(input logic r, input logic s);
    reset = r;
    sw_in = s;
    @(posedge clk);
    model_edge(r, s);
    #1;
  endtask

  task automatic check(input string name, input int step, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (step %0d): got %0b want %0b", name, step, act, exp);
    end
  endtask

  typedef struct packed {
    logic r;
    logic s;
    logic eo;
    logic er;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, input logic s, input logic eo, input logic er, input int n);
    for (int i = 0; i < n; i++) tbl.push_back('{r: r, s: s, eo: eo, er: er});
  endtask

  initial begin
    int   run_left;
    logic lvl;
    logic r;

    // reset held, then released with input low
    add(1, 0, 0, 0, 2);
    add(0, 0, 0, 0, 2);
    // steady press: edges e0..e3 counting, e4 flips with pulse
    add(0, 1, 0, 0, 4);
    add(0, 1, 1, 1, 1);
    add(0, 1, 1, 0, 2);
    // steady release: no pulse on the falling side
    add(0, 0, 1, 0, 4);
    add(0, 0, 0, 0, 2);
    // DEB-edge high glitch, then a full press proves the count restarted
    add(0, 1, 0, 0, 4);
    add(0, 0, 0, 0, 1);
    add(0, 1, 0, 0, 4);
    add(0, 1, 1, 1, 1);
    // short low glitch while high, then a full release
    add(0, 0, 1, 0, 2);
    add(0, 1, 1, 0, 1);
    add(0, 0, 1, 0, 4);
    add(0, 0, 0, 0, 1);

`ifndef SW_DEBOUNCE_SYNC_EN
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].r, tbl[i].s);
      check("tbl_out", i, sw_out, tbl[i].eo);
      check("tbl_rise", i, sw_rise, tbl[i].er);
    end
`endif

    // press from reset, latency includes synchronizer when enabled
    drive(1, 0);
    drive(1, 0);
    check("rst_out", 0, sw_out, 1'b0);
    check("rst_rise", 0, sw_rise, 1'b0);
    for (int e = 0; e <= 6 + LAT; e++) begin
      drive(0, 1);
      check("press_out", e, sw_out, e >= 4 + LAT);
      check("press_rise", e, sw_rise, e == 4 + LAT);
    end

    // reset during a held press forces full re-qualification
    drive(1, 0);
    drive(1, 0);
    for (int e = 0; e <= 9 + LAT; e++) begin
      r = (e == 2 || e == 3);
      drive(r, 1);
      check("requal_out", e, sw_out, e >= 8 + LAT);
      check("requal_rise", e, sw_rise, e == 8 + LAT);
    end

    // randomized bursty input with occasional resets
    drive(1, 0);
    run_left = 0;
    lvl      = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (run_left == 0) begin
        lvl      = 1'($urandom_range(0, 1));
        run_left = $urandom_range(1, 9);
      end
      run_left--;
      r = ($urandom_range(0, 149) == 0);
      drive(r, lvl);
      check("rand_out", i, sw_out, m_out);
      check("rand_rise", i, sw_rise, m_rise);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
